// File: rtl/fifo_rd_stream_if.sv
//==============================================================================
// Module   : fifo_rd_stream_if
// Brief    : FIFO read-port and valid/ready stream bundle for fifo_rd_stream.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface fifo_rd_stream_if #(
  parameter int W  = 4,
  parameter int CW = 16
);
  logic          fifo_re;
  logic [W-1:0]  fifo_rd;
  logic          fifo_empty;
  logic [W-1:0]  dout;
  logic          dout_valid;
  logic          dout_ready;
  logic [CW-1:0] words;

  modport master (
    output fifo_re,
    input  fifo_rd,
    input  fifo_empty,
    output dout,
    output dout_valid,
    input  dout_ready,
    output words
  );

  modport slave (
    input  fifo_re,
    output fifo_rd,
    output fifo_empty,
    input  dout,
    input  dout_valid,
    output dout_ready,
    input  words
  );
endinterface

`default_nettype wire

// File: rtl/fifo_rd_stream.sv
//==============================================================================
// Module   : fifo_rd_stream
// Brief    : Credit-based FIFO reader with RD_LAT+1 entry skid buffer and
//            valid/ready output stream.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module fifo_rd_stream #(
  parameter int W      = 4,
  parameter int RD_LAT = 1,
  parameter int CW     = 16
) (
  input  logic clk,
  input  logic rst_n,
  fifo_rd_stream_if.master bus
);

  localparam int c_D  = RD_LAT + 1;
  localparam int c_PW = $clog2(c_D);
  localparam int c_OW = $clog2(c_D + 1);
  localparam int c_SW = c_OW + 1;
  localparam logic [c_PW-1:0] c_PTR_LAST = c_PW'(c_D - 1);
  localparam logic [c_SW-1:0] c_DEPTH    = c_SW'(c_D);

  logic [W-1:0]      r_mem [c_D];
  logic [c_PW-1:0]   r_head;
  logic [c_PW-1:0]   r_tail;
  logic [c_OW-1:0]   r_occ;
  logic [RD_LAT-1:0] r_infl;
  logic [CW-1:0]     r_words;

  logic [c_SW-1:0]   w_ninfl;
  logic [c_SW-1:0]   w_sum;
  logic              w_push;
  logic              w_pop;
  logic              w_re;

  always_comb begin
    w_ninfl = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_ninfl = w_ninfl + c_SW'(r_infl[i]);
    end
  end

  // A read may be issued when the buffer plus in-flight words leave a free
  // slot, or when a pop this cycle frees one.
  assign w_sum  = c_SW'(r_occ) + w_ninfl;
  assign w_pop  = (r_occ != '0) && bus.dout_ready;
  assign w_push = r_infl[RD_LAT-1];
  assign w_re   = rst_n && !bus.fifo_empty && ((w_sum < c_DEPTH) || w_pop);

  assign bus.fifo_re    = w_re;
  assign bus.dout       = r_mem[r_head];
  assign bus.dout_valid = (r_occ != '0);
  assign bus.words      = r_words;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_occ   <= '0;
      r_infl  <= '0;
      r_words <= '0;
      for (int i = 0; i < c_D; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_infl[0] <= w_re;
      for (int i = 1; i < RD_LAT; i++) begin
        r_infl[i] <= r_infl[i-1];
      end

      // Depth need not be a power of two, so wrap pointers explicitly.
      if (w_push) begin
        r_mem[r_tail] <= bus.fifo_rd;
        r_tail        <= (r_tail == c_PTR_LAST) ? '0 : r_tail + c_PW'(1);
      end

      if (w_pop) begin
        r_head  <= (r_head == c_PTR_LAST) ? '0 : r_head + c_PW'(1);
        r_words <= r_words + CW'(1);
      end

      r_occ <= r_occ + c_OW'(w_push) - c_OW'(w_pop);
    end
  end

endmodule

`default_nettype wire
